// File: rtl/touch_prompt_pkg.sv
// Shared definitions for the touch prompt driver: bus register map,
// CTRL bit positions and FSM state encodings.
package touch_prompt_pkg;

    // Register addresses on the core bus
    localparam logic [7:0] ADDR_CTRL        = 8'h08;
    localparam logic [7:0] ADDR_STATUS      = 8'h09;
    localparam logic [7:0] ADDR_HALF_PERIOD = 8'h0a;
    localparam logic [7:0] ADDR_COUNT       = 8'h0b;

    // CTRL register bit positions
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_STOP_BIT  = 1;

    // Prompt FSM states; 2'h3 is never entered and falls back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'h0,
        ST_ON   = 2'h1,
        ST_OFF  = 2'h2
    } state_e;

endpackage

// File: rtl/touch_prompt.sv
// Touch prompt LED driver. Firmware sets a half-period and a blink count,
// then starts the block; it alternates ON/OFF phases of eff_period cycles
// each, for COUNT on/off cycles or forever when COUNT was 0 at START.
//
// Bus handshake: single-cycle. ready mirrors cs combinationally, read_data
// is valid in the same cycle cs is high, and a write (cs & we) commits on
// the clock edge that ends that cycle. There is no back-pressure.
module touch_prompt
    import touch_prompt_pkg::*;
#(
    parameter int                   CNT_WIDTH           = 24,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_HALF_PERIOD = 24'd3_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        led_out
);

    // Configuration registers
    logic [CNT_WIDTH-1:0] r_half_period;
    logic [7:0]           r_count;

    // Pattern state
    state_e               r_state;
    logic                 r_led;
    logic [CNT_WIDTH-1:0] r_phase_ctr;
    logic [7:0]           r_blink_ctr;
    logic                 r_infinite;

    // Bus decode
    logic                 w_wr;
    logic                 w_ctrl_wr;
    logic                 w_start;
    logic                 w_stop;
    logic                 w_busy;
    logic [CNT_WIDTH-1:0] w_eff_period;
    logic [CNT_WIDTH-1:0] w_reload;
    logic                 w_unused;

    assign w_wr      = cs & we;
    assign w_ctrl_wr = w_wr && (address == ADDR_CTRL);
    // STOP dominates a simultaneous START
    assign w_stop    = w_ctrl_wr & write_data[CTRL_STOP_BIT];
    assign w_start   = w_ctrl_wr & write_data[CTRL_START_BIT] & ~write_data[CTRL_STOP_BIT];
    assign w_busy    = (r_state != ST_IDLE);

    // A zero half-period still needs a one-cycle phase
    assign w_eff_period = (r_half_period == '0) ? CNT_WIDTH'(1) : r_half_period;
    assign w_reload     = w_eff_period - CNT_WIDTH'(1);

    // Only the low write_data bits reach registers; fold the rest away
    assign w_unused = ^write_data;

    assign ready   = cs;
    assign led_out = r_led;

    // Combinational read mux; zero when deselected, unmapped or write-only
    always_comb begin
        read_data = '0;
        if (cs) begin
            case (address)
                ADDR_STATUS:      read_data[0]           = w_busy;
                ADDR_HALF_PERIOD: read_data[CNT_WIDTH-1:0] = r_half_period;
                ADDR_COUNT:       read_data[7:0]         = r_count;
                default:          read_data              = '0;
            endcase
        end
    end

    // Configuration register writes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_half_period <= DEFAULT_HALF_PERIOD;
            r_count       <= '0;
        end else if (w_wr) begin
            if (address == ADDR_HALF_PERIOD) begin
                r_half_period <= write_data[CNT_WIDTH-1:0];
            end
            if (address == ADDR_COUNT) begin
                r_count <= write_data[7:0];
            end
        end
    end

    // Prompt FSM with registered LED; counters only decrement when nonzero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_led       <= 1'b0;
            r_phase_ctr <= '0;
            r_blink_ctr <= '0;
            r_infinite  <= 1'b0;
        end else if (w_stop) begin
            r_state <= ST_IDLE;
            r_led   <= 1'b0;
        end else if (w_start) begin
            // Fresh snapshot of COUNT; restarts from ON even if already busy
            r_state     <= ST_ON;
            r_led       <= 1'b1;
            r_phase_ctr <= w_reload;
            r_blink_ctr <= r_count;
            r_infinite  <= (r_count == 8'd0);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_led <= 1'b0;
                end
                ST_ON: begin
                    if (r_phase_ctr == '0) begin
                        r_phase_ctr <= w_reload;
                        r_state     <= ST_OFF;
                        r_led       <= 1'b0;
                    end else begin
                        r_phase_ctr <= r_phase_ctr - CNT_WIDTH'(1);
                    end
                end
                ST_OFF: begin
                    if (r_phase_ctr == '0) begin
                        if (r_infinite) begin
                            r_phase_ctr <= w_reload;
                            r_state     <= ST_ON;
                            r_led       <= 1'b1;
                        end else if (r_blink_ctr == 8'd1) begin
                            r_state <= ST_IDLE;
                            r_led   <= 1'b0;
                        end else begin
                            r_blink_ctr <= r_blink_ctr - 8'd1;
                            r_phase_ctr <= w_reload;
                            r_state     <= ST_ON;
                            r_led       <= 1'b1;
                        end
                    end else begin
                        r_phase_ctr <= r_phase_ctr - CNT_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_led   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_touch_prompt.sv
// Bench for touch_prompt: directed bus sequences push expected read data
// and expected LED levels into queues; a negedge monitor pops and compares.
module tb_touch_prompt;
    import touch_prompt_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        led_out;

    logic [31:0] exp_q[$];
    string       rd_nm_q[$];
    logic [0:0]  exp_led_q[$];
    string       led_nm_q[$];

    int total = 0;
    int bad   = 0;

    // Clock
    always #5 clk = ~clk;

    touch_prompt dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .we         (we),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .led_out    (led_out)
    );

    // Monitor / scoreboard: compare on the falling edge, away from updates
    always @(negedge clk) begin
        logic [31:0] e;
        logic [0:0]  el;
        string       nm;
        total++;
        if (ready !== cs) begin
            bad++;
            $display("FAIL ready: got %b expected %b", ready, cs);
        end
        if (cs === 1'b1 && we === 1'b0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read: addr %0h got %0h expected none", address, read_data);
            end else begin
                e  = exp_q.pop_front();
                nm = rd_nm_q.pop_front();
                if (read_data !== e) begin
                    bad++;
                    $display("FAIL %s: got %0h expected %0h", nm, read_data, e);
                end
            end
        end
        if (exp_led_q.size() > 0) begin
            total++;
            el = exp_led_q.pop_front();
            nm = led_nm_q.pop_front();
            if (led_out !== el[0]) begin
                bad++;
                $display("FAIL %s: got %b expected %b", nm, led_out, el[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; address = a; write_data = d;
        tick();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [31:0] e, input string nm);
        cs = 1'b1; we = 1'b0; address = a;
        exp_q.push_back(e);
        rd_nm_q.push_back(nm);
        tick();
        cs = 1'b0;
    endtask

    task automatic push_led(input logic v, input string nm);
        exp_led_q.push_back(v);
        led_nm_q.push_back(nm);
    endtask

    // Expected behaviour of cycle i (1 = first cycle after START) for
    // effective period p and count n (n = 0 means endless)
    function automatic logic pat_busy(input int p, input int n, input int i);
        return (n == 0) || (i <= 2 * n * p);
    endfunction

    function automatic logic pat_led(input int p, input int n, input int i);
        return pat_busy(p, n, i) && (((i - 1) / p) % 2 == 0);
    endfunction

    // Poll STATUS every cycle over pattern cycles a..b
    task automatic observe(input int p, input int n, input int a, input int b, input string tag);
        for (int i = a; i <= b; i++) begin
            push_led(pat_led(p, n, i), $sformatf("%s_led[%0d]", tag, i));
            exp_q.push_back({31'd0, pat_busy(p, n, i)});
            rd_nm_q.push_back($sformatf("%s_busy[%0d]", tag, i));
            cs = 1'b1; we = 1'b0; address = ADDR_STATUS;
            tick();
        end
        cs = 1'b0;
    endtask

    // Bus write issued during pattern cycle i
    task automatic write_in_pattern(input int p, input int n, input int i,
                                    input logic [7:0] a, input logic [31:0] d, input string tag);
        push_led(pat_led(p, n, i), $sformatf("%s_led[%0d]", tag, i));
        bus_write(a, d);
    endtask

    task automatic idle_check(input int k, input string tag);
        for (int i = 0; i < k; i++) begin
            push_led(1'b0, $sformatf("%s_led[%0d]", tag, i));
            exp_q.push_back(32'd0);
            rd_nm_q.push_back($sformatf("%s_busy[%0d]", tag, i));
            cs = 1'b1; we = 1'b0; address = ADDR_STATUS;
            tick();
        end
        cs = 1'b0;
    endtask

    task automatic start_pattern(input logic [31:0] hp, input logic [31:0] cnt);
        bus_write(ADDR_HALF_PERIOD, hp);
        bus_write(ADDR_COUNT, cnt);
        bus_write(ADDR_CTRL, 32'h1);
    endtask

    // Stimulus
    initial begin
        reset = 1'b1; cs = 1'b0; we = 1'b0; address = 8'h00; write_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset defaults and register map edges
        push_led(1'b0, "reset_led");
        bus_read(ADDR_STATUS,      32'd0,         "reset_status");
        bus_read(ADDR_HALF_PERIOD, 32'd3_000_000, "reset_half_period");
        bus_read(ADDR_COUNT,       32'd0,         "reset_count");
        bus_read(ADDR_CTRL,        32'd0,         "ctrl_reads_zero");
        bus_read(8'h00,            32'd0,         "unmapped_read");
        bus_write(ADDR_STATUS, 32'h1);
        bus_write(8'h20, 32'hffff_ffff);
        bus_read(ADDR_STATUS, 32'd0, "status_write_ignored");
        bus_write(ADDR_HALF_PERIOD, 32'hff12_3456);
        bus_read(ADDR_HALF_PERIOD, 32'h0012_3456, "half_period_upper_zero");
        bus_write(ADDR_COUNT, 32'h0000_01a5);
        bus_read(ADDR_COUNT, 32'h0000_00a5, "count_8bit");

        // Bounded blink: period 4, two cycles, BUSY falls at cycle 17
        start_pattern(32'd4, 32'd2);
        observe(4, 2, 1, 20, "blink4x2");

        // Zero period behaves as period 1
        start_pattern(32'd0, 32'd3);
        observe(1, 3, 1, 9, "zero_period");

        // Endless mode, then STOP
        start_pattern(32'd2, 32'd0);
        observe(2, 0, 1, 110, "endless");
        write_in_pattern(2, 0, 111, ADDR_CTRL, 32'h2, "endless");
        idle_check(3, "after_stop");

        // START and STOP together while idle
        bus_write(ADDR_CTRL, 32'h3);
        idle_check(3, "start_stop");

        // Restart during an OFF phase
        start_pattern(32'd4, 32'd2);
        observe(4, 2, 1, 6, "pre_restart");
        write_in_pattern(4, 2, 7, ADDR_CTRL, 32'h1, "pre_restart");
        observe(4, 2, 1, 20, "restarted");

        // COUNT rewrite mid-run leaves the running total unchanged
        start_pattern(32'd3, 32'd2);
        observe(3, 2, 1, 3, "count_rewrite");
        write_in_pattern(3, 2, 4, ADDR_COUNT, 32'd5, "count_rewrite");
        observe(3, 2, 5, 15, "count_rewrite");
        bus_read(ADDR_COUNT, 32'd5, "count_after_rewrite");

        // Reset in the middle of a pattern
        start_pattern(32'd8, 32'd4);
        observe(8, 4, 1, 4, "midreset");
        reset = 1'b1;
        push_led(pat_led(8, 4, 5), "midreset_led[5]");
        tick();
        reset = 1'b0;
        push_led(1'b0, "after_reset_led");
        bus_read(ADDR_STATUS,      32'd0,         "after_reset_status");
        bus_read(ADDR_HALF_PERIOD, 32'd3_000_000, "after_reset_half_period");
        bus_read(ADDR_COUNT,       32'd0,         "after_reset_count");

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/touch_prompt.md
# touch_prompt

User-prompt output driver: the output-side counterpart of the touch sensor handler. Firmware programs a half-period and a blink count over the core bus, then starts the block. The block drives the LED prompt pattern the user sees while the device waits for a touch, and reports busy status. It sits beside the touch sensor core on the same bus.

## Interface
Parameters:
- CNT_WIDTH, 24, width of the half-period register and phase counter.
- DEFAULT_HALF_PERIOD, 24'd3_000_000, half-period value loaded at reset.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  bus chip select.
- we  in  1  bus write enable, qualified by cs.
- address  in  8  register address.
- write_data  in  32  bus write data.
- read_data  out  32  bus read data; combinational; 0 when not selected or unmapped.
- ready  out  1  equals cs, combinational.
- led_out  out  1  prompt output, registered, 1 = lit.

## Operation
Register map:
- 0x08 CTRL, write-only.
  - bit0 START.
  - bit1 STOP.
- 0x09 STATUS, read-only.
  - bit0 BUSY, 1 when state != IDLE.
- 0x0a HALF_PERIOD, R/W, bits[CNT_WIDTH-1:0]; upper bits read 0.
- 0x0b COUNT, R/W, bits[7:0].
  - Number of on/off cycles.
  - 0 = blink until STOP.

FSM states are IDLE, ON and OFF, encoded 2'h0/2'h1/2'h2; 2'h3 is unreachable and recovers to IDLE.
- IDLE: led_out=0. On START, load phase_ctr=eff_period-1 and blink_ctr=COUNT, then go to ON.
- ON: led_out=1. When phase_ctr==0, reload phase_ctr and go to OFF; otherwise decrement.
- OFF: led_out=0. When phase_ctr==0:
  - If COUNT snapshot==0, reload and go to ON.
  - Else if blink_ctr==1, go to IDLE.
  - Else decrement blink_ctr, reload and go to ON.
  - When phase_ctr!=0, decrement.
- eff_period = HALF_PERIOD, or 1 when HALF_PERIOD==0.
- HALF_PERIOD is re-sampled at each reload, so writes while BUSY take effect from the next phase.
- COUNT is snapshotted at START (blink_ctr and an infinite flag). Later writes do not affect the running pattern.
- STOP in any state → IDLE next cycle, led_out=0.
- START and STOP in the same write: STOP wins.
- START while BUSY restarts the pattern from the ON phase with fresh snapshots.
- Writes to STATUS and reads of CTRL are ignored; both read 0 for CTRL.
- Unmapped addresses: writes ignored, reads 0.

## Timing
- Reset values:
  - state=IDLE, led_out=0, BUSY=0.
  - HALF_PERIOD=DEFAULT_HALF_PERIOD, COUNT=0.
  - phase_ctr=0, blink_ctr=0.
- Reset mid-pattern: next edge returns to all reset values; led_out=0 one cycle after reset is sampled high.
- The bus is single-cycle: ready=cs in the same cycle, read_data is valid in the same cycle, and writes commit on the edge ending the cs cycle.
- START written at edge t:
  - state=ON and led_out=1 from cycle t+1.
  - Each ON/OFF phase lasts exactly eff_period cycles.
- With COUNT=N≥1, BUSY is high for exactly 2·N·eff_period cycles, then drops in the same cycle led_out stays 0 in IDLE.
- STOP written at edge t: BUSY=0 and led_out=0 from cycle t+1.
- Counters wrap never: all decrements are guarded by the ==0 checks.

## Structure
- Shared core package/header: register addresses (ADDR_CTRL, ADDR_STATUS, ADDR_HALF_PERIOD, ADDR_COUNT), CTRL bit indices, and state encodings.
- Single module with no sub-modules. The phase counter is inline because it is too small to justify a separate block.

## Test plan
- Reset default: after reset, read STATUS=0, HALF_PERIOD=3_000_000, COUNT=0; led_out=0.
- Bounded blink: HALF_PERIOD=4, COUNT=2, START at edge t.
  - led_out high during cycles t+1..t+4 and t+9..t+12, low otherwise.
  - BUSY falls at t+17.
- Zero period: HALF_PERIOD=0, COUNT=3, START → led_out toggles every cycle for 6 cycles, then IDLE.
- Infinite mode: COUNT=0, HALF_PERIOD=2, START. The output toggles every 2 cycles for ≥100 cycles. STOP → BUSY=0 and led_out=0 on the next cycle.
- Simultaneous and restart cases:
  - CTRL=0x3 while idle → stays IDLE.
  - START mid-OFF phase → led_out=1 next cycle and the full pattern restarts.
  - Writing COUNT=5 mid-run does not change the blink total.
- Mid-run reset: HALF_PERIOD=8, COUNT=4, START. Assert reset at cycle 5 → led_out=0, BUSY=0, HALF_PERIOD reads 3_000_000 afterwards.
